hp_round_pipe: RTL and testbench

//  Pipelined half-precision rounding stage. Sits directly downstream of the hp_mul/addsub

---
 rtl/hp_round_pipe.sv | 135 +++++++++++++
 tb/tb_hp_round_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_round_pipe.sv
// Two-stage binary16 rounding pipeline: stage 1 decides the rounding increment (RN-even or
// stochastic via an internal Galois LFSR), stage 2 applies it and forms the final encoding.
module hp_round_pipe #(
  parameter int          EXT  = 11,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sr,
  input  logic              in_bypass,
  input  logic [15:0]       in_special,
  input  logic              in_sign,
  input  logic [4:0]        in_exp,
  input  logic [10+EXT:0]   in_sig,
  input  logic              seed_load,
  input  logic [15:0]       seed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_res,
  output logic              out_inexact,
  output logic              out_overflow
);

  // Handshake: a transfer happens on a rising edge where valid && ready on that side.
  // Each stage advances only when its successor can take it; out_* hold while !out_ready.
  logic        s2_ready;
  logic        accept;
  logic        s1_valid;
  logic        s1_sign;
  logic        s1_bypass;
  logic        s1_round_up;
  logic        s1_inexact;
  logic [4:0]  s1_exp;
  logic [10:0] s1_sig;
  logic [15:0] s1_special;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign accept   = in_valid && in_ready;
  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Stage 1 decision logic
  logic [EXT-1:0] low;
  logic [EXT-1:0] low_shl;
  logic           rn_up;
  logic           sr_up;
  logic           round_up_d;

  always_comb begin
    low        = in_sig[EXT-1:0];
    low_shl    = low << 1;  // drops the guard bit, leaving only the sticky bits
    rn_up      = in_sig[EXT-1] & ((|low_shl) | in_sig[EXT]);
    // low + r carries out of EXT bits exactly when low exceeds the complement of r
    sr_up      = low > ~lfsr[EXT-1:0];
    round_up_d = in_sr ? sr_up : rn_up;
  end

  // Stage 2 apply logic
  logic [11:0] m;
  logic [5:0]  exp_inc;
  logic [15:0] res_d;
  logic        inexact_d;
  logic        overflow_d;

  always_comb begin
    m          = {1'b0, s1_sig} + {11'b0, s1_round_up};
    exp_inc    = {1'b0, s1_exp} + 6'd1;
    res_d      = {s1_sign, s1_exp, m[9:0]};
    inexact_d  = s1_inexact;
    overflow_d = 1'b0;
    if (s1_bypass) begin
      res_d     = s1_special;
      inexact_d = 1'b0;
    end else if (m[11]) begin
      if (exp_inc == 6'd31) begin
        res_d      = {s1_sign, 5'h1F, 10'h000};
        overflow_d = 1'b1;
      end else begin
        res_d = {s1_sign, exp_inc[4:0], 10'h000};
      end
    end else if (s1_exp == 5'd0 && m[10]) begin
      res_d = {s1_sign, 5'd1, m[9:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_sign      <= 1'b0;
      s1_bypass    <= 1'b0;
      s1_round_up  <= 1'b0;
      s1_inexact   <= 1'b0;
      s1_exp       <= 5'd0;
      s1_sig       <= 11'd0;
      s1_special   <= 16'd0;
      out_valid    <= 1'b0;
      out_res      <= 16'd0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
      lfsr         <= SEED;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign     <= in_sign;
          s1_bypass   <= in_bypass;
          s1_special  <= in_special;
          s1_exp      <= in_exp;
          s1_sig      <= in_sig[10+EXT:EXT];
          s1_round_up <= round_up_d;
          s1_inexact  <= |low;
        end
      end
      if (s2_ready) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_res      <= res_d;
          out_inexact  <= inexact_d;
          out_overflow <= overflow_d;
        end
      end
      // The accepted SR transaction already sampled the old value in round_up_d
      if (seed_load) begin
        lfsr <= (seed == 16'd0) ? SEED : seed;
      end else if (accept && in_sr && !in_bypass) begin
        lfsr <= lfsr_next;
      end
    end
  end

endmodule

// File: tb/tb_hp_round_pipe.sv
// Bench for hp_round_pipe: directed vector table, randomized traffic against an arithmetic
// reference model, seed replay, backpressure and mid-flight reset sequences.
module tb_hp_round_pipe;
  localparam int          EXT  = 11;
  localparam int          SW   = 11 + EXT;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sr = 1'b0;
  logic          in_bypass = 1'b0;
  logic [15:0]   in_special = '0;
  logic          in_sign = 1'b0;
  logic [4:0]    in_exp = '0;
  logic [SW-1:0] in_sig = '0;
  logic          seed_load = 1'b0;
  logic [15:0]   seed = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [15:0]   out_res;
  logic          out_inexact;
  logic          out_overflow;

  hp_round_pipe #(.EXT(EXT), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sr(in_sr),
    .in_bypass(in_bypass), .in_special(in_special), .in_sign(in_sign), .in_exp(in_exp),
    .in_sig(in_sig), .seed_load(seed_load), .seed(seed), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_inexact(out_inexact),
    .out_overflow(out_overflow)
  );

  // clock / reset / ready shaping
  always #5 clk = ~clk;

  int rdy_mode = 0;  // 0 always, 1 random, 2 toggle, 3 hold low
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      2: out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
  end

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];  // {res, inexact, overflow}
  logic [15:0] model_lfsr = SEED;

  typedef struct {
    logic          sr;
    logic          bp;
    logic [15:0]   sp;
    logic          sgn;
    logic [4:0]    ex;
    logic [SW-1:0] sig;
    logic [17:0]   expv;
  } vec_t;
  vec_t vecs[13];

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Rounding by value: integer quotient/remainder, then add the increment to the packed
  // exponent:fraction word, which carries into the exponent naturally.
  function automatic logic [17:0] ref_model(input logic sr, input logic bp, input logic [15:0] sp,
      input logic sgn, input logic [4:0] ex, input logic [SW-1:0] sig, input logic [15:0] l);
    int unsigned q, r, full, half, enc;
    logic up;
    if (bp) return {sp, 2'b00};
    full = 1 << EXT;
    half = full / 2;
    q = int'(sig) / full;
    r = int'(sig) % full;
    if (sr) up = (r + (int'(l) % full)) >= full;
    else    up = (r > half) || (r == half && (q % 2) == 1);
    enc = int'(ex) * 1024 + (q % 1024) + (up ? 1 : 0);
    return {sgn, 15'(enc), r != 0, (enc / 1024) == 31};
  endfunction

  function automatic logic [SW-1:0] rand_sig(input logic [4:0] ex);
    logic [SW-1:0] s;
    s = SW'($urandom);
    s[SW-1] = (ex != 5'd0);
    return s;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    seed_load = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    model_lfsr = SEED;
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_load = 1'b1;
    seed = s;
    @(posedge clk);
    #1 seed_load = 1'b0;
    model_lfsr = (s == 16'd0) ? SEED : s;
  endtask

  // driver: called at posedge+#1, returns at posedge+#1 after the transfer
  task automatic send(input logic sr, input logic bp, input logic [15:0] sp, input logic sgn,
      input logic [4:0] ex, input logic [SW-1:0] sig, input logic use_tab, input logic [17:0] tab);
    logic got;
    got = 1'b0;
    in_valid = 1'b1; in_sr = sr; in_bypass = bp; in_special = sp;
    in_sign = sgn; in_exp = ex; in_sig = sig;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1 within 200 cycles", in_ready);
    end
    exp_q.push_back(use_tab ? tab : ref_model(sr, bp, sp, sgn, ex, sig, model_lfsr));
    if (seed_load) model_lfsr = (seed == 16'd0) ? SEED : seed;
    else if (sr && !bp) model_lfsr = lfsr_step(model_lfsr);
    @(posedge clk);
    #1 in_valid = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic send_rand(input logic sr);
    logic [4:0] ex;
    ex = 5'($urandom_range(0, 30));
    send(sr, 1'b0, 16'h0, 1'($urandom), ex, rand_sig(ex), 1'b0, 18'h0);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin done = 1'b1; break; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  task automatic monitor();
    logic held;
    logic [17:0] hold_val, got, want;
    held = 1'b0;
    hold_val = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        got = {out_res, out_inexact, out_overflow};
        if (held && out_valid) begin
          checks++;
          if (got !== hold_val) begin
            errors++;
            $display("FAIL stable: out=%h required held %h", got, hold_val);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: res=%h required no output", out_res);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL result: res=%h inexact=%b ovf=%b required res=%h inexact=%b ovf=%b",
                       out_res, out_inexact, out_overflow, want[17:2], want[1], want[0]);
            end
          end
        end
        held = out_valid && !out_ready;
        hold_val = got;
      end
    end
  endtask

  initial begin
    logic [4:0]    st_ex[30];
    logic [SW-1:0] st_sig[30];
    logic          st_sgn[30];

    vecs[0]  = '{1'b0, 1'b0, 16'h0, 1'b0, 5'd15, {11'h400, 11'h400}, {16'h3C00, 2'b10}};
    vecs[1]  = '{1'b0, 1'b0, 16'h0, 1'b0, 5'd15, {11'h401, 11'h400}, {16'h3C02, 2'b10}};
    vecs[2]  = '{1'b0, 1'b0, 16'h0, 1'b0, 5'd15, {11'h401, 11'h3FF}, {16'h3C01, 2'b10}};
    vecs[3]  = '{1'b0, 1'b0, 16'h0, 1'b0, 5'd15, {11'h7FF, 11'h7FF}, {16'h4000, 2'b10}};
    vecs[4]  = '{1'b0, 1'b0, 16'h0, 1'b0, 5'd30, {11'h7FF, 11'h7FF}, {16'h7C00, 2'b11}};
    vecs[5]  = '{1'b0, 1'b0, 16'h0, 1'b1, 5'd30, {11'h7FF, 11'h7FF}, {16'hFC00, 2'b11}};
    vecs[6]  = '{1'b0, 1'b1, 16'h7E00, 1'b0, 5'd3, {11'h7FF, 11'h7FF}, {16'h7E00, 2'b00}};
    vecs[7]  = '{1'b0, 1'b0, 16'h0, 1'b0, 5'd0, {11'h3FF, 11'h400}, {16'h0400, 2'b10}};
    vecs[8]  = '{1'b0, 1'b0, 16'h0, 1'b0, 5'd10, {11'h555, 11'h000}, {16'h2955, 2'b00}};
    vecs[9]  = '{1'b1, 1'b0, 16'h0, 1'b0, 5'd15, {11'h400, 11'h000}, {16'h3C00, 2'b00}};
    vecs[10] = '{1'b1, 1'b0, 16'h0, 1'b0, 5'd15, {11'h400, 11'h7FF}, {16'h3C01, 2'b10}};
    vecs[11] = '{1'b0, 1'b0, 16'h0, 1'b0, 5'd0, {11'h000, 11'h001}, {16'h0000, 2'b10}};
    vecs[12] = '{1'b0, 1'b0, 16'h0, 1'b1, 5'd20, {11'h4FF, 11'h401}, {16'hD100, 2'b10}};

    fork monitor(); join_none

    do_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_res !== 16'h0 || out_inexact !== 1'b0 ||
        out_overflow !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b res=%h inx=%b ovf=%b in_ready=%b required 0 0000 0 0 1",
               out_valid, out_res, out_inexact, out_overflow, in_ready);
    end
    @(posedge clk);
    #1;

    // directed table (SR rows rely on the LFSR being fresh from reset)
    for (int i = 0; i < 13; i++)
      send(vecs[i].sr, vecs[i].bp, vecs[i].sp, vecs[i].sgn, vecs[i].ex, vecs[i].sig, 1'b1,
           vecs[i].expv);
    drain();

    // SR with all-ones discard bits over 1000 transactions from the reset seed
    do_reset();
    for (int i = 0; i < 1000; i++)
      send(1'b1, 1'b0, 16'h0, 1'($urandom), 5'd15, {1'b1, 10'($urandom), 11'h7FF}, 1'b0, 18'h0);
    drain();

    // seed replay with identical stimulus, zero seed, and seed_load alongside an SR transfer
    for (int i = 0; i < 30; i++) begin
      st_ex[i] = 5'($urandom_range(0, 30));
      st_sig[i] = rand_sig(st_ex[i]);
      st_sgn[i] = 1'($urandom);
    end
    for (int pass = 0; pass < 2; pass++) begin
      load_seed(16'h1234);
      for (int i = 0; i < 30; i++)
        send(1'b1, 1'b0, 16'h0, st_sgn[i], st_ex[i], st_sig[i], 1'b0, 18'h0);
    end
    load_seed(16'h0000);
    for (int i = 0; i < 5; i++) send_rand(1'b1);
    seed_load = 1'b1;
    seed = 16'h8001;
    send_rand(1'b1);
    for (int i = 0; i < 5; i++) send_rand(1'b1);
    drain();

    // mixed random traffic under random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        send(1'($urandom), 1'b1, 16'($urandom), 1'b0, 5'd0, '0, 1'b0, 18'h0);
      else
        send_rand(1'($urandom));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain();

    // 8 back-to-back SR inputs, toggling ready with a 5-cycle stall in the middle
    rdy_mode = 2;
    fork
      begin
        repeat (6) @(posedge clk);
        rdy_mode = 3;
        repeat (5) @(posedge clk);
        rdy_mode = 2;
      end
    join_none
    for (int i = 0; i < 8; i++)
      send(1'b1, 1'b0, 16'h0, 1'b0, 5'd15, {1'b1, 10'($urandom), 11'h7FF}, 1'b0, 18'h0);
    drain();
    rdy_mode = 0;
    for (int i = 0; i < 4; i++)
      send(1'b1, 1'b0, 16'h0, 1'b0, 5'd15, {1'b1, 10'($urandom), 11'h7FF}, 1'b0, 18'h0);
    drain();

    // reset with two transactions in flight
    rdy_mode = 3;
    @(posedge clk);
    #1;
    send_rand(1'b1);
    send_rand(1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    model_lfsr = SEED;
    rdy_mode = 0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flush: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_quiet: out_valid=%b required 0", out_valid);
      end
    end
    @(posedge clk);
    #1;
    send(1'b1, 1'b0, 16'h0, 1'b0, 5'd15, {11'h400, 11'h7FF}, 1'b0, 18'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
